// File: rtl/l4_multi_generator.sv
`timescale 1ns/1ps
// Multi-channel L4 trigger generator: samples masked per-channel flags, opens a readout window
// sized by the lowest-index firing channel, and tracks sources, retriggers and dropped events.
module l4_multi_generator #(
    parameter int unsigned NCH         = 4,
    parameter int unsigned NBLOCK_BITS = 8,
    parameter int unsigned CPB_LOG2    = 1,
    parameter int unsigned RETRIG_MODE = 0,
    parameter int unsigned DROP_BITS   = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [NCH-1:0]             l4_i,
    input  logic [NCH-1:0]             mask_i,
    input  logic [NCH*NBLOCK_BITS-1:0] blocks_i,
    input  logic                       drop_clr_i,
    output logic                       l4_o,
    output logic                       l4_new_o,
    output logic [NCH-1:0]             l4_src_o,
    output logic [NBLOCK_BITS-1:0]     l4_blocks_o,
    output logic [NCH-1:0]             l4_scaler_o,
    output logic [DROP_BITS-1:0]       drop_count_o
);

    localparam int unsigned CW = NBLOCK_BITS + CPB_LOG2 + 1;

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    state_e                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [NCH-1:0]         hit_q;
    logic [NBLOCK_BITS-1:0] nblk_q;
    logic [NCH-1:0]         src_q;
    logic [NBLOCK_BITS-1:0] blk_q;
    logic [NCH-1:0]         scaler_q;
    logic [1:0]             new_cnt_q;
    logic [DROP_BITS-1:0]   drop_q;

    logic [NCH-1:0]         hit_d;
    logic [NBLOCK_BITS-1:0] win_blocks_d;
    logic [CW-1:0]          load_val;
    logic                   evt;
    logic                   accept;
    logic                   drop;

    assign hit_d = l4_i & ~mask_i;

    // Lowest-index hit wins; scanning downwards leaves the lowest one in place.
    always_comb begin
        win_blocks_d = '0;
        for (int k = int'(NCH) - 1; k >= 0; k--) begin
            if (hit_d[k]) begin
                win_blocks_d = blocks_i[k*NBLOCK_BITS +: NBLOCK_BITS];
            end
        end
    end

    assign load_val = ((CW'(nblk_q) + CW'(1)) << CPB_LOG2) - CW'(1);
    assign evt      = |hit_q;
    assign accept   = evt && (state_q == StIdle || cnt_q == '0 || RETRIG_MODE != 0);
    assign drop     = evt && !accept;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hit_q     <= '0;
            nblk_q    <= '0;
            src_q     <= '0;
            blk_q     <= '0;
            scaler_q  <= '0;
            new_cnt_q <= '0;
            drop_q    <= '0;
        end else begin
            hit_q    <= hit_d;
            nblk_q   <= win_blocks_d;
            scaler_q <= l4_i;

            if (accept) begin
                state_q   <= StActive;
                cnt_q     <= load_val;
                src_q     <= hit_q;
                blk_q     <= nblk_q;
                new_cnt_q <= 2'd2;
            end else begin
                if (state_q == StActive) begin
                    if (cnt_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                if (new_cnt_q != 2'd0) begin
                    new_cnt_q <= new_cnt_q - 2'd1;
                end
            end

            // Clear wins over a coincident drop; the counter saturates instead of wrapping.
            if (drop_clr_i) begin
                drop_q <= '0;
            end else if (drop && drop_q != '1) begin
                drop_q <= drop_q + DROP_BITS'(1);
            end
        end
    end

    assign l4_o         = (state_q == StActive);
    assign l4_new_o     = (new_cnt_q != 2'd0);
    assign l4_src_o     = src_q;
    assign l4_blocks_o  = blk_q;
    assign l4_scaler_o  = scaler_q;
    assign drop_count_o = drop_q;

endmodule

// File: tb/tb_l4_multi_generator.sv
`timescale 1ns/1ps
// Directed bench for l4_multi_generator: default, restart-mode and 2-bit-drop instances
// share one stimulus stream; each task checks its own scenario.
module tb_l4_multi_generator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  l4;
    logic [3:0]  mask;
    logic [31:0] blocks;
    logic        drop_clr;

    logic        o0_l4, o0_new;
    logic [3:0]  o0_src, o0_sc;
    logic [7:0]  o0_blk;
    logic [15:0] o0_drop;
    logic        o1_l4, o1_new;
    logic [3:0]  o1_src, o1_sc;
    logic [7:0]  o1_blk;
    logic [15:0] o1_drop;
    logic        o2_l4, o2_new;
    logic [3:0]  o2_src, o2_sc;
    logic [7:0]  o2_blk;
    logic [1:0]  o2_drop;

    int n_checks = 0;
    int n_fail   = 0;

    int r0_first, r0_len, r0_rises, r0_new, r0_nrises;
    int r1_first, r1_len, r1_rises, r1_new, r1_nrises;
    int sc_first, sc_cnt;

    always #5 clk = ~clk;

    l4_multi_generator dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .l4_i(l4), .mask_i(mask), .blocks_i(blocks),
        .drop_clr_i(drop_clr), .l4_o(o0_l4), .l4_new_o(o0_new), .l4_src_o(o0_src),
        .l4_blocks_o(o0_blk), .l4_scaler_o(o0_sc), .drop_count_o(o0_drop)
    );

    l4_multi_generator #(.RETRIG_MODE(1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .l4_i(l4), .mask_i(mask), .blocks_i(blocks),
        .drop_clr_i(drop_clr), .l4_o(o1_l4), .l4_new_o(o1_new), .l4_src_o(o1_src),
        .l4_blocks_o(o1_blk), .l4_scaler_o(o1_sc), .drop_count_o(o1_drop)
    );

    l4_multi_generator #(.DROP_BITS(2)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .l4_i(l4), .mask_i(mask), .blocks_i(blocks),
        .drop_clr_i(drop_clr), .l4_o(o2_l4), .l4_new_o(o2_new), .l4_src_o(o2_src),
        .l4_blocks_o(o2_blk), .l4_scaler_o(o2_sc), .drop_count_o(o2_drop)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_drops();
        drop_clr = 1'b1;
        tick();
        drop_clr = 1'b0;
    endtask

    // Index c = state after the (c+1)-th edge following the first flag.
    task automatic run_seq(input logic [3:0] f1, input logic [3:0] f2, input int k2,
                           input logic [31:0] b1, input logic [31:0] b2,
                           input logic [3:0] m1, input logic [3:0] m2, input int ncyc);
        logic p0, p1, pn0, pn1;
        r0_first = -1; r0_len = 0; r0_rises = 0; r0_new = 0; r0_nrises = 0;
        r1_first = -1; r1_len = 0; r1_rises = 0; r1_new = 0; r1_nrises = 0;
        sc_first = 0; sc_cnt = 0;
        p0 = 1'b0; p1 = 1'b0; pn0 = 1'b0; pn1 = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            l4     = (c == 0) ? f1 : ((k2 > 0 && c == k2) ? f2 : 4'b0000);
            blocks = (k2 > 0 && c >= k2) ? b2 : b1;
            mask   = (k2 > 0 && c >= k2) ? m2 : m1;
            tick();
            if (o0_l4) begin
                if (r0_first < 0) r0_first = c;
                r0_len++;
                if (!p0) r0_rises++;
            end
            if (o1_l4) begin
                if (r1_first < 0) r1_first = c;
                r1_len++;
                if (!p1) r1_rises++;
            end
            if (o0_new) begin
                r0_new++;
                if (!pn0) r0_nrises++;
            end
            if (o1_new) begin
                r1_new++;
                if (!pn1) r1_nrises++;
            end
            if (o0_sc[0]) begin
                sc_cnt++;
                if (c == 0) sc_first = 1;
            end
            p0 = o0_l4; p1 = o1_l4; pn0 = o0_new; pn1 = o1_new;
        end
        l4 = 4'b0000;
        mask = 4'b0000;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; l4 = '0; mask = '0; blocks = '0; drop_clr = 1'b0;
        #3;
        n_checks++;
        if ({o0_l4, o0_new, o0_src, o0_blk, o0_sc, o0_drop} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0",
                     {o0_l4, o0_new, o0_src, o0_blk, o0_sc, o0_drop});
        end
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
    endtask

    task automatic test_single();
        run_seq(4'b0001, 4'b0000, 0, 32'h00000003, 32'h00000003, 4'b0, 4'b0, 14);
        n_checks++;
        if (r0_first !== 1) begin
            n_fail++; $display("FAIL single_latency: got %0d required 1", r0_first);
        end
        n_checks++;
        if (r0_len !== 8 || r0_rises !== 1) begin
            n_fail++; $display("FAIL single_len: got %0d/%0d required 8/1", r0_len, r0_rises);
        end
        n_checks++;
        if (r0_new !== 2 || r0_nrises !== 1) begin
            n_fail++; $display("FAIL single_new: got %0d/%0d required 2/1", r0_new, r0_nrises);
        end
        n_checks++;
        if (o0_src !== 4'b0001 || o0_blk !== 8'd3) begin
            n_fail++; $display("FAIL single_src_blk: got %b/%0d required 0001/3", o0_src, o0_blk);
        end
        n_checks++;
        if (sc_first !== 1 || sc_cnt !== 1) begin
            n_fail++; $display("FAIL single_scaler: got %0d/%0d required 1/1", sc_first, sc_cnt);
        end
    endtask

    task automatic test_multi_channel();
        run_seq(4'b0110, 4'b0000, 0, 32'h00020500, 32'h00020500, 4'b0, 4'b0, 16);
        n_checks++;
        if (o0_src !== 4'b0110 || o0_blk !== 8'd5) begin
            n_fail++; $display("FAIL multi_src_blk: got %b/%0d required 0110/5", o0_src, o0_blk);
        end
        n_checks++;
        if (r0_len !== 12 || r0_rises !== 1) begin
            n_fail++; $display("FAIL multi_len: got %0d/%0d required 12/1", r0_len, r0_rises);
        end
    endtask

    task automatic test_retrig_ignore();
        clear_drops();
        run_seq(4'b0001, 4'b1000, 4, 32'h01000004, 32'h01000004, 4'b0, 4'b0, 16);
        n_checks++;
        if (r0_len !== 10 || r0_rises !== 1) begin
            n_fail++; $display("FAIL ignore_len: got %0d/%0d required 10/1", r0_len, r0_rises);
        end
        n_checks++;
        if (o0_drop !== 16'd1) begin
            n_fail++; $display("FAIL ignore_drop: got %0d required 1", o0_drop);
        end
        n_checks++;
        if (o0_src !== 4'b0001 || o0_blk !== 8'd4) begin
            n_fail++; $display("FAIL ignore_src_blk: got %b/%0d required 0001/4", o0_src, o0_blk);
        end
        n_checks++;
        if (r1_len !== 8 || r1_rises !== 1 || o1_drop !== 16'd0) begin
            n_fail++;
            $display("FAIL restart_b3: got %0d/%0d/%0d required 8/1/0", r1_len, r1_rises, o1_drop);
        end
    endtask

    task automatic test_back_to_back();
        run_seq(4'b0001, 4'b1000, 10, 32'h01000004, 32'h01000004, 4'b0, 4'b0, 20);
        n_checks++;
        if (r0_len !== 14 || r0_rises !== 1) begin
            n_fail++; $display("FAIL b2b_len: got %0d/%0d required 14/1", r0_len, r0_rises);
        end
        n_checks++;
        if (r0_new !== 4 || r0_nrises !== 2) begin
            n_fail++; $display("FAIL b2b_new: got %0d/%0d required 4/2", r0_new, r0_nrises);
        end
        n_checks++;
        if (o0_drop !== 16'd1 || o0_src !== 4'b1000 || o0_blk !== 8'd1) begin
            n_fail++;
            $display("FAIL b2b_state: got %0d/%b/%0d required 1/1000/1", o0_drop, o0_src, o0_blk);
        end
    endtask

    task automatic test_retrig_restart();
        clear_drops();
        run_seq(4'b0001, 4'b0010, 4, 32'h00000004, 32'h00000004, 4'b0, 4'b0, 16);
        n_checks++;
        if (r1_first !== 1 || r1_len !== 6 || r1_rises !== 1) begin
            n_fail++;
            $display("FAIL restart_len: got %0d/%0d/%0d required 1/6/1", r1_first, r1_len, r1_rises);
        end
        n_checks++;
        if (r1_new !== 4 || r1_nrises !== 2) begin
            n_fail++; $display("FAIL restart_new: got %0d/%0d required 4/2", r1_new, r1_nrises);
        end
        n_checks++;
        if (o1_src !== 4'b0010 || o1_blk !== 8'd0 || o1_drop !== 16'd0) begin
            n_fail++;
            $display("FAIL restart_state: got %b/%0d/%0d required 0010/0/0", o1_src, o1_blk, o1_drop);
        end
    endtask

    task automatic test_mask();
        clear_drops();
        run_seq(4'b0001, 4'b0000, 0, 32'h00000003, 32'h00000003, 4'b0001, 4'b0001, 10);
        n_checks++;
        if (r0_len !== 0 || r0_new !== 0) begin
            n_fail++; $display("FAIL mask_window: got %0d/%0d required 0/0", r0_len, r0_new);
        end
        n_checks++;
        if (sc_first !== 1 || sc_cnt !== 1) begin
            n_fail++; $display("FAIL mask_scaler: got %0d/%0d required 1/1", sc_first, sc_cnt);
        end
        // blocks0 grows and ch0/ch3 get masked mid-window; a masked ch3 flag arrives too
        run_seq(4'b0001, 4'b1000, 3, 32'h00000003, 32'h00000014, 4'b0000, 4'b1001, 14);
        n_checks++;
        if (r0_len !== 8 || r0_rises !== 1) begin
            n_fail++; $display("FAIL mask_midwin_len: got %0d/%0d required 8/1", r0_len, r0_rises);
        end
        n_checks++;
        if (o0_drop !== 16'd0) begin
            n_fail++; $display("FAIL mask_drop: got %0d required 0", o0_drop);
        end
    endtask

    task automatic test_saturation();
        int guard;
        clear_drops();
        blocks = 32'h00000014;
        for (int c = 0; c < 16; c++) begin
            l4 = (c == 0) ? 4'b0001 :
                 ((c >= 2 && c <= 10 && c % 2 == 0) || c == 14) ? 4'b1000 : 4'b0000;
            drop_clr = (c == 15);
            tick();
            if (c == 12) begin
                n_checks++;
                if (o2_drop !== 2'd3 || o0_drop !== 16'd5 || o1_drop !== 16'd0) begin
                    n_fail++;
                    $display("FAIL sat_drop: got %0d/%0d/%0d required 3/5/0",
                             o2_drop, o0_drop, o1_drop);
                end
            end
        end
        drop_clr = 1'b0;
        l4 = 4'b0000;
        n_checks++;
        if (o0_drop !== 16'd0 || o2_drop !== 2'd0) begin
            n_fail++; $display("FAIL clr_priority: got %0d/%0d required 0/0", o0_drop, o2_drop);
        end
        guard = 0;
        while ((o0_l4 || o1_l4 || o2_l4) && guard < 100) begin
            tick();
            guard++;
        end
        n_checks++;
        if (guard >= 100) begin
            n_fail++; $display("FAIL sat_window_end: got timeout required idle");
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        blocks = 32'h00000003;
        l4 = 4'b0001;
        tick();
        l4 = 4'b0000;
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o0_l4, o0_new, o0_src, o0_blk, o0_sc, o0_drop} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h required 0",
                     {o0_l4, o0_new, o0_src, o0_blk, o0_sc, o0_drop});
        end
        tick(); tick(); tick();
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (o0_l4 || o0_new || o0_src != 4'b0) stray++;
        end
        n_checks++;
        if (stray !== 0) begin
            n_fail++; $display("FAIL reset_quiet: got %0d active cycles required 0", stray);
        end
        run_seq(4'b0001, 4'b0000, 0, 32'h00000003, 32'h00000003, 4'b0, 4'b0, 12);
        n_checks++;
        if (r0_first !== 1 || r0_len !== 8) begin
            n_fail++; $display("FAIL reset_fresh: got %0d/%0d required 1/8", r0_first, r0_len);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_channel();
        test_retrig_ignore();
        test_back_to_back();
        test_retrig_restart();
        test_mask();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
